generic_bus_arbiter: RTL and testbench

Two-requester arbiter sharing one generic bus, for example the instruction fetch and data memory ports, onto a single downstream generic bus that feeds the AHB manager bridge.

- Each transfer is captured into an internal request register when it is granted, so the downstream bus sees stable signals for the whole transfer.
- Only one transfer is outstanding at a time.
- Grants are round-robin or fixed-priority, selected by parameter.

---
 rtl/generic_bus_if.sv | 32 +++
 rtl/generic_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_generic_bus_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/generic_bus_if.sv
// ============================================================================
// Module      : generic_bus_if
// Description : Generic single-transfer memory bus. The requester drives the
//               address/data/strobe signals; the responder returns rdata and
//               holds busy high until the transfer completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  byte_en;
  logic        ren;
  logic        wen;
  logic        busy;

  // Responder view: accepts a transfer, answers with rdata/busy
  modport generic_bus (
    input  addr, wdata, byte_en, ren, wen,
    output rdata, busy
  );

  // Requester view: issues a transfer, waits on rdata/busy
  modport cpu (
    output addr, wdata, byte_en, ren, wen,
    input  rdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/generic_bus_arbiter.sv
// ============================================================================
// Module      : generic_bus_arbiter
// Description : Two-requester arbiter onto one downstream generic bus. The
//               granted transfer is captured in a request register so the
//               downstream bus stays stable for the whole transfer. Only one
//               transfer is outstanding at a time; arbitration is round-robin
//               (FIXED_PRIO=0) or port-0-wins (FIXED_PRIO=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module generic_bus_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                CLK,
  input  logic                nRST,
  generic_bus_if.generic_bus  m0_gen_bus_if,
  generic_bus_if.generic_bus  m1_gen_bus_if,
  generic_bus_if.cpu          out_gen_bus_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_grant_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  byte_en_q;
  logic        ren_q;
  logic        wen_q;

  logic        req0;
  logic        req1;
  logic        pick1;
  logic        grant0_d;
  logic        grant1_d;
  logic        release_d;

  assign req0 = m0_gen_bus_if.ren | m0_gen_bus_if.wen;
  assign req1 = m1_gen_bus_if.ren | m1_gen_bus_if.wen;

  // Port 1 wins if it is the only requester, or on a round-robin tie when
  // port 0 was the last port served.
  assign pick1 = req1 & (~req0 | ((FIXED_PRIO == 0) & ~last_grant_q));

  // Grant/release decision for this cycle. At completion only the other port
  // is considered: the port just served still holds its strobes this cycle.
  always_comb begin
    grant0_d  = 1'b0;
    grant1_d  = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant1_d = pick1;
        grant0_d = req0 & ~pick1;
      end
      GNT0: begin
        if (!out_gen_bus_if.busy) begin
          grant1_d  = req1;
          release_d = ~req1;
        end
      end
      GNT1: begin
        if (!out_gen_bus_if.busy) begin
          grant0_d  = req0;
          release_d = ~req0;
        end
      end
      default: release_d = 1'b1;
    endcase
  end

  // State, last-grant and request register; a read+write request is
  // captured as a read.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_en_q    <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
    end else if (grant0_d) begin
      state_q      <= GNT0;
      last_grant_q <= 1'b0;
      addr_q       <= m0_gen_bus_if.addr;
      wdata_q      <= m0_gen_bus_if.wdata;
      byte_en_q    <= m0_gen_bus_if.byte_en;
      ren_q        <= m0_gen_bus_if.ren;
      wen_q        <= m0_gen_bus_if.wen & ~m0_gen_bus_if.ren;
    end else if (grant1_d) begin
      state_q      <= GNT1;
      last_grant_q <= 1'b1;
      addr_q       <= m1_gen_bus_if.addr;
      wdata_q      <= m1_gen_bus_if.wdata;
      byte_en_q    <= m1_gen_bus_if.byte_en;
      ren_q        <= m1_gen_bus_if.ren;
      wen_q        <= m1_gen_bus_if.wen & ~m1_gen_bus_if.ren;
    end else if (release_d) begin
      state_q      <= IDLE;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
    end
  end

  // Downstream bus straight from the request register; strobes are cleared
  // whenever the arbiter is idle.
  assign out_gen_bus_if.addr    = addr_q;
  assign out_gen_bus_if.wdata   = wdata_q;
  assign out_gen_bus_if.byte_en = byte_en_q;
  assign out_gen_bus_if.ren     = ren_q;
  assign out_gen_bus_if.wen     = wen_q;

  // Only the granted port sees the downstream busy; everyone else waits.
  assign m0_gen_bus_if.busy  = (state_q != GNT0) | out_gen_bus_if.busy;
  assign m1_gen_bus_if.busy  = (state_q != GNT1) | out_gen_bus_if.busy;
  assign m0_gen_bus_if.rdata = out_gen_bus_if.rdata;
  assign m1_gen_bus_if.rdata = out_gen_bus_if.rdata;

endmodule

`default_nettype wire

// File: tb/tb_generic_bus_arbiter.sv
// ============================================================================
// Module      : tb_generic_bus_arbiter
// Description : Directed bench for generic_bus_arbiter. A round-robin and a
//               fixed-priority instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_generic_bus_arbiter;

  logic CLK;
  logic nRST;

  // Shared stimulus
  logic        s_r0, s_w0, s_r1, s_w1, s_obusy;
  logic [31:0] s_a0, s_d0, s_a1, s_d1, s_ordata;
  logic [3:0]  s_be0, s_be1;

  int checks;
  int failures;

  generic_bus_if rr_m0();
  generic_bus_if rr_m1();
  generic_bus_if rr_out();
  generic_bus_if fp_m0();
  generic_bus_if fp_m1();
  generic_bus_if fp_out();

  assign rr_m0.ren = s_r0;  assign rr_m0.wen = s_w0;  assign rr_m0.addr = s_a0;
  assign rr_m0.wdata = s_d0; assign rr_m0.byte_en = s_be0;
  assign rr_m1.ren = s_r1;  assign rr_m1.wen = s_w1;  assign rr_m1.addr = s_a1;
  assign rr_m1.wdata = s_d1; assign rr_m1.byte_en = s_be1;
  assign rr_out.busy = s_obusy; assign rr_out.rdata = s_ordata;
  assign fp_m0.ren = s_r0;  assign fp_m0.wen = s_w0;  assign fp_m0.addr = s_a0;
  assign fp_m0.wdata = s_d0; assign fp_m0.byte_en = s_be0;
  assign fp_m1.ren = s_r1;  assign fp_m1.wen = s_w1;  assign fp_m1.addr = s_a1;
  assign fp_m1.wdata = s_d1; assign fp_m1.byte_en = s_be1;
  assign fp_out.busy = s_obusy; assign fp_out.rdata = s_ordata;

  generic_bus_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .CLK(CLK), .nRST(nRST),
    .m0_gen_bus_if(rr_m0), .m1_gen_bus_if(rr_m1), .out_gen_bus_if(rr_out)
  );

  generic_bus_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .CLK(CLK), .nRST(nRST),
    .m0_gen_bus_if(fp_m0), .m1_gen_bus_if(fp_m1), .out_gen_bus_if(fp_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        r0, w0; logic [31:0] a0, d0; logic [3:0] be0;
    logic        r1, w1; logic [31:0] a1, d1; logic [3:0] be1;
    logic        obusy;  logic [31:0] ordata;
    logic        e_ren, e_wen; logic [31:0] e_addr, e_wdata; logic [3:0] e_be;
    logic        e_b0, e_b1;
    logic        chk_bus;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_stim(input logic r0, input logic w0, input logic [31:0] a0,
                          input logic [31:0] d0, input logic [3:0] be0,
                          input logic r1, input logic w1, input logic [31:0] a1,
                          input logic [31:0] d1, input logic [3:0] be1,
                          input logic obusy, input logic [31:0] ordata);
    s_r0 = r0; s_w0 = w0; s_a0 = a0; s_d0 = d0; s_be0 = be0;
    s_r1 = r1; s_w1 = w1; s_a1 = a1; s_d1 = d1; s_be1 = be1;
    s_obusy = obusy; s_ordata = ordata;
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST     = 1'b0;
    set_stim(0,0,0,0,0, 0,0,0,0,0, 1,0);

    // r0 w0 a0 d0 be0 | r1 w1 a1 d1 be1 | obusy ordata | ren wen addr wdata be | b0 b1 | chk_bus
    // Simultaneous pair straight after reset: port 0 then port 1 back-to-back
    vecs[0]  = '{1,0,32'h100,0,4'hF, 0,1,32'h200,32'h55AA55AA,4'h3, 1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 1};
    vecs[1]  = '{1,0,32'h100,0,4'hF, 0,1,32'h200,32'h55AA55AA,4'h3, 0,32'h11111111, 1,0,32'h100,0,4'hF,               0,1, 1};
    vecs[2]  = '{0,0,32'h0,0,4'h0,   0,1,32'h200,32'h55AA55AA,4'h3, 1,32'h0,        0,1,32'h200,32'h55AA55AA,4'h3,    1,1, 1};
    vecs[3]  = '{0,0,32'h0,0,4'h0,   0,1,32'h200,32'h55AA55AA,4'h3, 0,32'h22222222, 0,1,32'h200,32'h55AA55AA,4'h3,    1,0, 1};
    vecs[4]  = '{0,0,32'h0,0,4'h0,   0,0,32'h0,0,4'h0,              0,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    // Single read from port 0
    vecs[5]  = '{1,0,32'h1000,0,4'hF, 0,0,32'h0,0,4'h0,             1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    vecs[6]  = '{1,0,32'h1000,0,4'hF, 0,0,32'h0,0,4'h0,             1,32'h0,        1,0,32'h1000,0,4'hF,              1,1, 1};
    vecs[7]  = '{1,0,32'h1000,0,4'hF, 0,0,32'h0,0,4'h0,             0,32'hDEADBEEF, 1,0,32'h1000,0,4'hF,              0,1, 1};
    vecs[8]  = '{0,0,32'h0,0,4'h0,    0,0,32'h0,0,4'h0,             1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    // Second simultaneous pair: port 0 was served last, so port 1 goes first
    vecs[9]  = '{1,0,32'h300,0,4'hF, 1,0,32'h400,0,4'hF,            1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    vecs[10] = '{1,0,32'h300,0,4'hF, 1,0,32'h400,0,4'hF,            1,32'h0,        1,0,32'h400,0,4'hF,               1,1, 1};
    vecs[11] = '{1,0,32'h300,0,4'hF, 1,0,32'h400,0,4'hF,            0,32'h33333333, 1,0,32'h400,0,4'hF,               1,0, 1};
    vecs[12] = '{1,0,32'h300,0,4'hF, 0,0,32'h0,0,4'h0,              0,32'h44444444, 1,0,32'h300,0,4'hF,               0,1, 1};
    vecs[13] = '{0,0,32'h0,0,4'h0,   0,0,32'h0,0,4'h0,              1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    // Port 1 write with five wait states
    vecs[14] = '{0,0,32'h0,0,4'h0, 0,1,32'h500,32'hCAFEF00D,4'hC,   1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    vecs[15] = '{0,0,32'h0,0,4'h0, 0,1,32'h500,32'hCAFEF00D,4'hC,   1,32'h0,        0,1,32'h500,32'hCAFEF00D,4'hC,    1,1, 1};
    vecs[16] = vecs[15];
    vecs[17] = vecs[15];
    vecs[18] = vecs[15];
    vecs[19] = vecs[15];
    vecs[20] = '{0,0,32'h0,0,4'h0, 0,1,32'h500,32'hCAFEF00D,4'hC,   0,32'h55555555, 0,1,32'h500,32'hCAFEF00D,4'hC,    1,0, 1};
    vecs[21] = '{0,0,32'h0,0,4'h0, 0,0,32'h0,0,4'h0,                1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    // Port 0 drops its read one cycle after grant
    vecs[22] = '{1,0,32'h600,0,4'hF, 0,0,32'h0,0,4'h0,              1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    vecs[23] = '{0,0,32'h0,0,4'h0,   0,0,32'h0,0,4'h0,              1,32'h0,        1,0,32'h600,0,4'hF,               1,1, 1};
    vecs[24] = '{0,0,32'h0,0,4'h0,   0,0,32'h0,0,4'h0,              0,32'h66666666, 1,0,32'h600,0,4'hF,               0,1, 1};
    vecs[25] = '{0,0,32'h0,0,4'h0,   0,0,32'h0,0,4'h0,              0,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    vecs[26] = '{0,0,32'h0,0,4'h0,   0,0,32'h0,0,4'h0,              1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    // Read and write together from port 1 is captured as a read
    vecs[27] = '{0,0,32'h0,0,4'h0, 1,1,32'h700,32'h77777777,4'hF,   1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};
    vecs[28] = '{0,0,32'h0,0,4'h0, 1,1,32'h700,32'h77777777,4'hF,   0,32'h88888888, 1,0,32'h700,32'h77777777,4'hF,    1,0, 1};
    vecs[29] = '{0,0,32'h0,0,4'h0, 0,0,32'h0,0,4'h0,                1,32'h0,        0,0,32'h0,0,4'h0,                 1,1, 0};

    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;

    for (int i = 0; i < 30; i++) begin
      set_stim(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, vecs[i].be0,
               vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].be1,
               vecs[i].obusy, vecs[i].ordata);
      @(negedge CLK);
      chk($sformatf("v%0d out.ren", i),  {31'b0, rr_out.ren},  {31'b0, vecs[i].e_ren});
      chk($sformatf("v%0d out.wen", i),  {31'b0, rr_out.wen},  {31'b0, vecs[i].e_wen});
      chk($sformatf("v%0d m0.busy", i),  {31'b0, rr_m0.busy},  {31'b0, vecs[i].e_b0});
      chk($sformatf("v%0d m1.busy", i),  {31'b0, rr_m1.busy},  {31'b0, vecs[i].e_b1});
      chk($sformatf("v%0d m0.rdata", i), rr_m0.rdata, vecs[i].ordata);
      chk($sformatf("v%0d m1.rdata", i), rr_m1.rdata, vecs[i].ordata);
      if (vecs[i].chk_bus) begin
        chk($sformatf("v%0d out.addr", i),    rr_out.addr,  vecs[i].e_addr);
        chk($sformatf("v%0d out.wdata", i),   rr_out.wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d out.byte_en", i), {28'b0, rr_out.byte_en}, {28'b0, vecs[i].e_be});
      end
      next_cycle();
    end

    // Fixed priority vs round-robin on an idle tie after port 0 was served
    set_stim(0,0,0,0,0, 0,0,0,0,0, 1,0);
    pulse_reset();
    set_stim(1,0,32'h800,0,4'hF, 0,0,0,0,0, 1,0);
    next_cycle();
    set_stim(1,0,32'h800,0,4'hF, 0,0,0,0,0, 0,32'h1);
    @(negedge CLK);
    chk("fp solo addr", fp_out.addr, 32'h800);
    chk("fp solo m0.busy", {31'b0, fp_m0.busy}, 32'd0);
    next_cycle();
    set_stim(1,0,32'h800,0,4'hF, 0,1,32'h900,32'h12345678,4'hF, 1,0);
    @(negedge CLK);
    chk("fp tie idle ren", {31'b0, fp_out.ren}, 32'd0);
    next_cycle();
    set_stim(1,0,32'h800,0,4'hF, 0,1,32'h900,32'h12345678,4'hF, 0,0);
    @(negedge CLK);
    chk("fp tie winner addr", fp_out.addr, 32'h800);
    chk("fp tie m0.busy", {31'b0, fp_m0.busy}, 32'd0);
    chk("fp tie m1.busy", {31'b0, fp_m1.busy}, 32'd1);
    chk("rr tie winner addr", rr_out.addr, 32'h900);
    chk("rr tie m1.busy", {31'b0, rr_m1.busy}, 32'd0);
    next_cycle();
    @(negedge CLK);
    chk("fp b2b addr", fp_out.addr, 32'h900);
    chk("fp b2b wen", {31'b0, fp_out.wen}, 32'd1);
    chk("fp b2b m1.busy", {31'b0, fp_m1.busy}, 32'd0);
    chk("rr b2b addr", rr_out.addr, 32'h800);
    chk("rr b2b ren", {31'b0, rr_out.ren}, 32'd1);
    next_cycle();
    @(negedge CLK);
    chk("fp regrant addr", fp_out.addr, 32'h800);
    chk("fp regrant m0.busy", {31'b0, fp_m0.busy}, 32'd0);

    // Asynchronous reset in the middle of a port 1 transfer
    set_stim(0,0,0,0,0, 0,0,0,0,0, 1,0);
    next_cycle();
    pulse_reset();
    set_stim(0,0,0,0,0, 0,1,32'hA00,32'hA5A5A5A5,4'hF, 1,0);
    next_cycle();
    @(negedge CLK);
    chk("pre-reset wen", {31'b0, rr_out.wen}, 32'd1);
    chk("pre-reset addr", rr_out.addr, 32'hA00);
    #2;
    nRST = 1'b0;
    #1;
    chk("mid reset ren", {31'b0, rr_out.ren}, 32'd0);
    chk("mid reset wen", {31'b0, rr_out.wen}, 32'd0);
    chk("mid reset addr", rr_out.addr, 32'd0);
    chk("mid reset m0.busy", {31'b0, rr_m0.busy}, 32'd1);
    chk("mid reset m1.busy", {31'b0, rr_m1.busy}, 32'd1);
    chk("mid reset fp wen", {31'b0, fp_out.wen}, 32'd0);
    next_cycle();
    nRST = 1'b1;
    set_stim(1,0,32'hB00,0,4'hF, 0,1,32'hA00,32'hA5A5A5A5,4'hF, 1,0);
    @(negedge CLK);
    chk("post reset idle ren", {31'b0, rr_out.ren}, 32'd0);
    chk("post reset idle wen", {31'b0, rr_out.wen}, 32'd0);
    next_cycle();
    @(negedge CLK);
    chk("post reset rr winner", rr_out.addr, 32'hB00);
    chk("post reset rr ren", {31'b0, rr_out.ren}, 32'd1);
    chk("post reset fp winner", fp_out.addr, 32'hB00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
